// File: rtl/tl_pkg.sv
// rtl/tl_pkg.sv - shared traffic-light timing constants and derived counter widths
package tl_pkg;

    localparam int CLK_HZ     = 48_000_000;
    localparam int SAMPLE_HZ  = 1000;
    localparam int DB_SAMPLES = 20;
    localparam int DIV        = CLK_HZ / SAMPLE_HZ;

    localparam int N_SENS = 3;
    localparam int N_PB   = 3;
    localparam int N_CH   = N_SENS + N_PB;

    // Bits needed to hold 0..n-1, never below one so a degenerate count stays a legal vector.
    function automatic int cnt_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    localparam int DIV_W = cnt_w(DIV);
    localparam int SEC_W = cnt_w(SAMPLE_HZ);
    localparam int DB_W  = cnt_w(DB_SAMPLES);

endpackage

// File: rtl/input_conditioner_if.sv
// rtl/input_conditioner_if.sv - raw inputs, acks and conditioned outputs of the input conditioner
interface input_conditioner_if;

    logic SNN, SNS, STH;
    logic PNN, PNS, PTH;
    logic ACK_NN, ACK_NS, ACK_TH;
    logic SNN_Q, SNS_Q, STH_Q;
    logic REQ_NN, REQ_NS, REQ_TH;
    logic SENS_CHG, TICK_MS, TICK_S;

    modport master (
        output SNN, SNS, STH, PNN, PNS, PTH, ACK_NN, ACK_NS, ACK_TH,
        input  SNN_Q, SNS_Q, STH_Q, REQ_NN, REQ_NS, REQ_TH, SENS_CHG, TICK_MS, TICK_S
    );

    modport slave (
        input  SNN, SNS, STH, PNN, PNS, PTH, ACK_NN, ACK_NS, ACK_TH,
        output SNN_Q, SNS_Q, STH_Q, REQ_NN, REQ_NS, REQ_TH, SENS_CHG, TICK_MS, TICK_S
    );

endinterface

// File: rtl/debounce_ch.sv
// rtl/debounce_ch.sv - two-flop synchronizer plus tick-sampled debounce for one raw input
module debounce_ch #(
    parameter int DB_SAMPLES = tl_pkg::DB_SAMPLES
) (
    input  logic CLK,
    input  logic RST,
    input  logic tick,
    input  logic raw,
    output logic level
);

    localparam int DB_W = tl_pkg::cnt_w(DB_SAMPLES);
    localparam logic [DB_W-1:0] CNT_LAST = DB_W'(DB_SAMPLES - 1);

    logic            sync_1;
    logic            sync_2;
    logic [DB_W-1:0] count;

    always_ff @(posedge CLK) begin
        if (RST) begin
            sync_1 <= 1'b0;
            sync_2 <= 1'b0;
        end else begin
            sync_1 <= raw;
            sync_2 <= sync_1;
        end
    end

    // Any agreeing sample restarts the run, so only an unbroken run of DB_SAMPLES flips the level.
    always_ff @(posedge CLK) begin
        if (RST) begin
            level <= 1'b0;
            count <= '0;
        end else if (tick) begin
            if (sync_2 == level) begin
                count <= '0;
            end else if (count == CNT_LAST) begin
                level <= ~level;
                count <= '0;
            end else begin
                count <= count + 1'b1;
            end
        end
    end

endmodule

// File: rtl/input_conditioner.sv
// rtl/input_conditioner.sv - sample ticks, debounced sensors, SENS_CHG strobe and pedestrian request latches
module input_conditioner #(
    parameter int CLK_HZ     = tl_pkg::CLK_HZ,
    parameter int SAMPLE_HZ  = tl_pkg::SAMPLE_HZ,
    parameter int DB_SAMPLES = tl_pkg::DB_SAMPLES
) (
    input  logic               CLK,
    input  logic               RST,
    input_conditioner_if.slave io
);

    localparam int DIV   = CLK_HZ / SAMPLE_HZ;
    localparam int DIV_W = tl_pkg::cnt_w(DIV);
    localparam int SEC_W = tl_pkg::cnt_w(SAMPLE_HZ);
    localparam int N_CH  = tl_pkg::N_CH;
    localparam logic [DIV_W-1:0] PRE_LAST = DIV_W'(DIV - 1);
    localparam logic [SEC_W-1:0] SEC_LAST = SEC_W'(SAMPLE_HZ - 1);

    logic [DIV_W-1:0] pre_cnt;
    logic [SEC_W-1:0] sec_cnt;
    logic             tick_ms;
    logic             tick_s;
    logic [N_CH-1:0]  raw;
    logic [N_CH-1:0]  level;
    logic [N_CH-1:0]  level_prev;
    logic [2:0]       ack;
    logic [2:0]       set_ev;
    logic [2:0]       req;
    logic             sens_chg;

    always_comb begin
        tick_ms = (pre_cnt == PRE_LAST);
        tick_s  = tick_ms && (sec_cnt == SEC_LAST);
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            pre_cnt <= '0;
            sec_cnt <= '0;
        end else begin
            pre_cnt <= tick_ms ? '0 : pre_cnt + 1'b1;
            if (tick_ms) begin
                sec_cnt <= tick_s ? '0 : sec_cnt + 1'b1;
            end
        end
    end

    // Bits 2:0 are the vehicle sensors, bits 5:3 the pushbuttons, NN/NS/TH order in each group.
    assign raw = {io.PTH, io.PNS, io.PNN, io.STH, io.SNS, io.SNN};
    assign ack = {io.ACK_TH, io.ACK_NS, io.ACK_NN};

    for (genvar i = 0; i < N_CH; i++) begin : g_ch
        debounce_ch #(.DB_SAMPLES(DB_SAMPLES)) u_ch (
            .CLK   (CLK),
            .RST   (RST),
            .tick  (tick_ms),
            .raw   (raw[i]),
            .level (level[i])
        );
    end

    // level_prev clears in reset, so an input held high through reset still shows a fresh rising edge.
    always_ff @(posedge CLK) begin
        if (RST) begin
            level_prev <= '0;
            req        <= '0;
        end else begin
            level_prev <= level;
            req        <= set_ev | (req & ~ack);
        end
    end

    always_comb begin
        set_ev   = level[5:3] & ~level_prev[5:3];
        sens_chg = |(level[2:0] ^ level_prev[2:0]);
    end

    assign io.SNN_Q    = level[0];
    assign io.SNS_Q    = level[1];
    assign io.STH_Q    = level[2];
    assign io.REQ_NN   = req[0];
    assign io.REQ_NS   = req[1];
    assign io.REQ_TH   = req[2];
    assign io.SENS_CHG = sens_chg;
    assign io.TICK_MS  = tick_ms;
    assign io.TICK_S   = tick_s;

endmodule

// File: doc/input_conditioner.md
INPUT_CONDITIONER -- requirements
Module: input_conditioner

Interface
REQ-001 CLK_HZ, 48000000, input clock frequency in Hz.
REQ-002 SAMPLE_HZ, 1000, debounce sample and TICK_MS rate in Hz; CLK_HZ SHALL be an integer multiple of it.
REQ-003 DB_SAMPLES, 20, number of consecutive agreeing samples needed to flip a debounced level.
REQ-004 CLK  input  1  single clock, 48 MHz; all logic SHALL be clocked on its rising edge.
REQ-005 RST  input  1  reset, synchronous, active-high.
REQ-006 SNN, SNS, STH  input  1 each  raw, asynchronous vehicle sensors (Norton Norte, Norton Sur, third approach).
REQ-007 PNN, PNS, PTH  input  1 each  raw, asynchronous, active-high pedestrian pushbuttons.
REQ-008 ACK_NN, ACK_NS, ACK_TH  input  1 each  request-clear strobes from the traffic FSM.
REQ-009 SNN_Q, SNS_Q, STH_Q  output  1 each  debounced sensor levels.
REQ-010 REQ_NN, REQ_NS, REQ_TH  output  1 each  latched pedestrian requests.
REQ-011 SENS_CHG  output  1  one-cycle strobe: some debounced sensor level changed.
REQ-012 TICK_MS  output  1  one-cycle strobe at SAMPLE_HZ.
REQ-013 TICK_S  output  1  one-cycle strobe at 1 Hz, used as the FSM phase-time base.

Function
REQ-014 Each of the six raw inputs SHALL pass through a 2-flop synchronizer before any other use.
REQ-015 Prescaler: counts 0..DIV-1 with DIV = CLK_HZ/SAMPLE_HZ, then wraps to 0; TICK_MS SHALL be high exactly in the cycle the count equals DIV-1.
REQ-016 Second counter: counts TICK_MS strobes 0..SAMPLE_HZ-1; TICK_S SHALL be high in the same cycle as the TICK_MS that wraps it.
REQ-017 Debounce, per channel: state is a stable level plus a count; samples are taken only on TICK_MS cycles.
REQ-018 On a tick where the synced input equals the stable level, count SHALL clear to 0.
REQ-019 On a tick where it differs, count SHALL increment; on the DB_SAMPLES-th consecutive differing tick, the stable level SHALL invert and count SHALL clear.
REQ-020 The debounced output SHALL change in the cycle after that tick; a bounce shorter than DB_SAMPLES ticks SHALL produce no output change.
REQ-021 SENS_CHG SHALL be high for exactly the one cycle in which any of SNN_Q, SNS_Q or STH_Q differs from its previous-cycle value; simultaneous changes give one strobe.
REQ-022 A rising edge of a debounced pushbutton SHALL set the matching REQ_x in the next cycle.
REQ-023 Holding the button SHALL NOT re-set the request; a new set requires release (debounced 0) followed by a new press.
REQ-024 ACK_x high SHALL clear REQ_x in the next cycle.
REQ-025 If a set event and ACK_x coincide, set SHALL win and REQ_x SHALL be 1.
REQ-026 ACK_x while REQ_x is 0 SHALL have no effect.
REQ-027 Pushbutton debounced levels are internal only and SHALL NOT affect SENS_CHG.

Reset
REQ-028 While RST is high at a clock edge, the following SHALL all load 0: synchronizer flops, prescaler, second counter, debounce counts, stable levels, REQ_x, SENS_CHG, TICK_MS and TICK_S.
REQ-029 Reset mid-debounce SHALL discard all partial counts.
REQ-030 After release, the prescaler SHALL restart from 0.
REQ-031 A raw input held at 1 through reset SHALL be reported, after release, as a normal 0->1 transition, including its SENS_CHG strobe.

Structure
REQ-032 A shared package tl_pkg SHALL hold CLK_HZ, SAMPLE_HZ, DB_SAMPLES and the derived counter widths: clog2(DIV), clog2(SAMPLE_HZ) and clog2(DB_SAMPLES).
REQ-033 The traffic FSM SHALL import tl_pkg for its phase-time tables.
REQ-034 One sub-module, debounce_ch (synchronizer + debounce for a single channel), SHALL be instantiated six times.
REQ-035 The prescaler, second counter, request latches and SENS_CHG logic SHALL live in input_conditioner.

Verification (bench parameters: CLK_HZ=4000, SAMPLE_HZ=1000, DB_SAMPLES=3)
REQ-036 Idle after reset: release RST -> TICK_MS high at cycles 3, 7, 11, ... after release; TICK_S first high at cycle 3999, then every 4000 cycles.
REQ-037 Clean step: SNN 0->1 held -> SNN_Q rises one cycle after the 3rd tick that samples the synced 1; SENS_CHG is a single 1-cycle pulse in that same cycle.
REQ-038 Bounce: SNN high for 2 ticks, then low -> SNN_Q stays 0 and SENS_CHG stays 0.
REQ-039 Button held 20 ticks: PNS held -> REQ_NS sets once; ACK_NS pulse clears it; it stays 0 while PNS is held; release then re-press sets it again.
REQ-040 Collision: ACK_TH asserted in the same cycle as the PTH set event -> REQ_TH = 1.
REQ-041 Reset mid-debounce: assert RST after 2 of 3 agreeing ticks -> all outputs 0; after release, 3 full ticks are needed before STH_Q = 1.
